conv_input_interface: RTL and testbench



---
 rtl/conv_input_interface.sv | 230 +++++++++++++++++++++++
 tb/tb_conv_input_interface.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/conv_input_interface.sv
// rtl/conv_input_interface.sv - image-side responder for the conv controller input channel
// Fetches image rows from a synchronous ROM into a rotating line buffer and streams per-tap pixel vectors.
module conv_input_interface #(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_SIZE  = 8,
  parameter int ARRAY_SIZE  = 6,
  parameter int ADDR_WIDTH  = 6,
  parameter int ROM_DEPTH   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  cmd_i,
  output logic [1:0]                  ack_o,
  output logic                        rom_rd_en_o,
  output logic [ADDR_WIDTH-1:0]       rom_addr_o,
  input  logic [WIDTH-1:0]            rom_data_i,
  output logic                        data_valid_o,
  output logic [3:0]                  tap_idx_o,
  output logic [WIDTH*ARRAY_SIZE-1:0] data_out_o,
  output logic                        busy_o
);

  localparam int NTAPS     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PRE_WORDS = KERNEL_SIZE * IMAGE_SIZE;
  localparam int CW        = $clog2(PRE_WORDS + 1);
  localparam int SW        = (KERNEL_SIZE > 2) ? $clog2(KERNEL_SIZE) : 1;
  localparam int SW1       = SW + 1;
  localparam int CLW       = (IMAGE_SIZE > 2) ? $clog2(IMAGE_SIZE) : 1;
  localparam int DW        = WIDTH * ARRAY_SIZE;

  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_SHIFT   = 2'd2,
    S_LOAD    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              ack_q, ack_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    dv_q, dv_d;
  logic [3:0]              tap_q, tap_d;
  logic [DW-1:0]           dout_q, dout_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]           base_q, base_d;
  logic [CW-1:0]           iss_cnt_q, iss_cnt_d;
  logic                    cap_en_q, cap_en_d;
  logic [CW-1:0]           cap_cnt_q, cap_cnt_d;

  logic [WIDTH-1:0]        lb_q [KERNEL_SIZE][IMAGE_SIZE];
  logic                    lb_we;
  logic [SW-1:0]           cap_slot;
  logic [CLW-1:0]          cap_col;
  logic [CW-1:0]           words_n;

  logic [3:0]              sel_tap;
  logic [SW-1:0]           sel_row;
  logic [SW-1:0]           sel_slot;
  logic [CLW-1:0]          sel_col;
  logic [SW:0]             slot_sum;
  logic [DW-1:0]           tap_vec;
  logic [SW-1:0]           base_inc;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(ROM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Tap vector for the tap about to be presented: row picks a logical line, column shifts the lane window.
  always_comb begin
    sel_tap  = (state_q == S_SHIFT) ? tap_q + 4'd1 : 4'd0;
    sel_row  = SW'(sel_tap / 4'(KERNEL_SIZE));
    sel_col  = CLW'(sel_tap % 4'(KERNEL_SIZE));
    slot_sum = {1'b0, base_q} + {1'b0, sel_row};
    sel_slot = (slot_sum >= SW1'(KERNEL_SIZE)) ? SW'(slot_sum - SW1'(KERNEL_SIZE))
                                                : slot_sum[SW-1:0];
    tap_vec  = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      tap_vec[i*WIDTH +: WIDTH] = lb_q[sel_slot][CLW'(i) + sel_col];
    end
  end

  always_comb begin
    words_n  = (state_q == S_PRELOAD) ? CW'(PRE_WORDS) : CW'(IMAGE_SIZE);
    cap_slot = (state_q == S_PRELOAD) ? SW'(cap_cnt_q / CW'(IMAGE_SIZE)) : base_q;
    cap_col  = CLW'(cap_cnt_q % CW'(IMAGE_SIZE));
    base_inc = (base_q == SW'(KERNEL_SIZE - 1)) ? '0 : base_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 2'd0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    dv_d      = 1'b0;
    tap_d     = tap_q;
    dout_d    = dout_q;
    rd_ptr_d  = rd_ptr_q;
    base_d    = base_q;
    iss_cnt_d = iss_cnt_q;
    cap_en_d  = rd_en_q;
    cap_cnt_d = cap_cnt_q;
    lb_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        case (cmd_i)
          CMD_PRELOAD: begin
            state_d   = S_PRELOAD;
            rd_en_d   = 1'b1;
            addr_d    = '0;
            rd_ptr_d  = ptr_inc('0);
            base_d    = '0;
            iss_cnt_d = CW'(1);
            cap_cnt_d = '0;
          end
          CMD_SHIFT: begin
            state_d = S_SHIFT;
            dv_d    = 1'b1;
            tap_d   = 4'd0;
            dout_d  = tap_vec;
          end
          CMD_LOAD: begin
            state_d   = S_LOAD;
            rd_en_d   = 1'b1;
            addr_d    = rd_ptr_q;
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            iss_cnt_d = CW'(1);
            cap_cnt_d = '0;
          end
          default: ;
        endcase
      end
      S_PRELOAD, S_LOAD: begin
        if (iss_cnt_q < words_n) begin
          rd_en_d   = 1'b1;
          addr_d    = rd_ptr_q;
          rd_ptr_d  = ptr_inc(rd_ptr_q);
          iss_cnt_d = iss_cnt_q + CW'(1);
        end
        // ROM data lags the read strobe by one cycle; the last capture closes the command.
        if (cap_en_q) begin
          lb_we     = 1'b1;
          cap_cnt_d = cap_cnt_q + CW'(1);
          if (cap_cnt_q == words_n - CW'(1)) begin
            state_d = S_IDLE;
            if (state_q == S_PRELOAD) begin
              ack_d = CMD_PRELOAD;
            end else begin
              ack_d  = CMD_LOAD;
              base_d = base_inc;
            end
          end
        end
      end
      S_SHIFT: begin
        if (tap_q != 4'(NTAPS - 1)) begin
          dv_d   = 1'b1;
          tap_d  = sel_tap;
          dout_d = tap_vec;
        end else begin
          ack_d   = CMD_SHIFT;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ack_q     <= 2'd0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      dv_q      <= 1'b0;
      tap_q     <= 4'd0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      rd_ptr_q  <= '0;
      base_q    <= '0;
      iss_cnt_q <= '0;
      cap_en_q  <= 1'b0;
      cap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      dv_q      <= dv_d;
      tap_q     <= tap_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      rd_ptr_q  <= rd_ptr_d;
      base_q    <= base_d;
      iss_cnt_q <= iss_cnt_d;
      cap_en_q  <= cap_en_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < KERNEL_SIZE; s++) begin
        for (int c = 0; c < IMAGE_SIZE; c++) begin
          lb_q[s][c] <= '0;
        end
      end
    end else if (lb_we) begin
      lb_q[cap_slot][cap_col] <= rom_data_i;
    end
  end

  assign ack_o        = ack_q;
  assign rom_rd_en_o  = rd_en_q;
  assign rom_addr_o   = addr_q;
  assign data_valid_o = dv_q;
  assign tap_idx_o    = tap_q;
  assign data_out_o   = dout_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_conv_input_interface.sv
// tb/tb_conv_input_interface.sv - randomized bench for conv_input_interface
// Per-cycle expectations come from a row/slot model of the line buffer and a bench-owned ROM.
module tb_conv_input_interface;

  localparam int WIDTH       = 32;
  localparam int KERNEL_SIZE = 3;
  localparam int IMAGE_SIZE  = 8;
  localparam int ARRAY_SIZE  = 6;
  localparam int ADDR_WIDTH  = 6;
  localparam int ROM_DEPTH   = 64;
  localparam int DW          = WIDTH * ARRAY_SIZE;
  localparam int NTAPS       = KERNEL_SIZE * KERNEL_SIZE;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            cmd;
  logic [1:0]            ack;
  logic                  rom_rd_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0]      rom_data;
  logic                  data_valid;
  logic [3:0]            tap_idx;
  logic [DW-1:0]         data_out;
  logic                  busy;

  logic [WIDTH-1:0]      rom_mem [ROM_DEPTH];
  logic [WIDTH-1:0]      mlb [KERNEL_SIZE][IMAGE_SIZE];
  int                    mbase;
  int                    mptr;
  logic [DW-1:0]         mlast;
  int                    n_tests = 0;
  int                    n_fail  = 0;
  bit                    positioned;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd_en) rom_data <= rom_mem[rom_addr];

  conv_input_interface #(
    .WIDTH(WIDTH), .KERNEL_SIZE(KERNEL_SIZE), .IMAGE_SIZE(IMAGE_SIZE),
    .ARRAY_SIZE(ARRAY_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .ROM_DEPTH(ROM_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_i(cmd), .ack_o(ack),
    .rom_rd_en_o(rom_rd_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .data_valid_o(data_valid), .tap_idx_o(tap_idx), .data_out_o(data_out),
    .busy_o(busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ack"},   DW'(ack),        '0);
    check({tag, " rd_en"}, DW'(rom_rd_en),  '0);
    check({tag, " addr"},  DW'(rom_addr),   '0);
    check({tag, " dv"},    DW'(data_valid), '0);
    check({tag, " tap"},   DW'(tap_idx),    '0);
    check({tag, " dout"},  data_out,        '0);
    check({tag, " busy"},  DW'(busy),       '0);
  endtask

  task automatic model_reset();
    for (int s = 0; s < KERNEL_SIZE; s++)
      for (int c = 0; c < IMAGE_SIZE; c++) mlb[s][c] = '0;
    mbase = 0;
    mptr  = 0;
    mlast = '0;
  endtask

  function automatic logic [DW-1:0] model_vec(input int t);
    logic [DW-1:0] v;
    int slot;
    slot = (mbase + t / KERNEL_SIZE) % KERNEL_SIZE;
    for (int i = 0; i < ARRAY_SIZE; i++) v[i*WIDTH +: WIDTH] = mlb[slot][i + t % KERNEL_SIZE];
    return v;
  endfunction

  function automatic int ack_cycle(input logic [1:0] c);
    if (c == 2'd1) return KERNEL_SIZE * IMAGE_SIZE + 2;
    if (c == 2'd3) return IMAGE_SIZE + 2;
    return NTAPS + 1;
  endfunction

  // Drives one command and checks every cycle up to its acknowledge (plus one idle cycle unless chained).
  task automatic run_cmd(input logic [1:0] c, input int ign_k, input logic [1:0] ign_c,
                         input int rst_k, input bit chain);
    int ack_k, nwords, start_ptr, last_k;
    bit exp_rd, exp_dv;
    logic [DW-1:0] ev;
    string tg;
    ack_k     = ack_cycle(c);
    nwords    = (c == 2'd1) ? KERNEL_SIZE * IMAGE_SIZE : (c == 2'd3) ? IMAGE_SIZE : 0;
    start_ptr = (c == 2'd1) ? 0 : mptr;
    last_k    = chain ? ack_k : ack_k + 1;
    if (!positioned) @(negedge clk);
    cmd = c;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 1 || k == ign_k + 1) cmd = 2'd0;
      tg = $sformatf("cmd%0d cyc%0d", c, k);
      exp_rd = (k <= nwords);
      check({tg, " rd_en"}, DW'(rom_rd_en), DW'(exp_rd));
      if (exp_rd) check({tg, " addr"}, DW'(rom_addr), DW'((start_ptr + k - 1) % ROM_DEPTH));
      exp_dv = (c == 2'd2) && (k <= NTAPS);
      check({tg, " dv"}, DW'(data_valid), DW'(exp_dv));
      if (exp_dv) begin
        ev = model_vec(k - 1);
        check({tg, " tap"}, DW'(tap_idx), DW'(k - 1));
        check({tg, " dout"}, data_out, ev);
        mlast = ev;
      end else begin
        check({tg, " dout_hold"}, data_out, mlast);
      end
      check({tg, " ack"}, DW'(ack), (k == ack_k) ? DW'(c) : '0);
      check({tg, " busy"}, DW'(busy), DW'(k < ack_k));
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tg, " rst"});
        model_reset();
        cmd = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        positioned = 1'b0;
        return;
      end
      if (k == ign_k) cmd = ign_c;
    end
    if (c == 2'd1) begin
      for (int j = 0; j < KERNEL_SIZE; j++)
        for (int col = 0; col < IMAGE_SIZE; col++) mlb[j][col] = rom_mem[j * IMAGE_SIZE + col];
      mbase = 0;
      mptr  = (KERNEL_SIZE * IMAGE_SIZE) % ROM_DEPTH;
    end else if (c == 2'd3) begin
      for (int col = 0; col < IMAGE_SIZE; col++) mlb[mbase][col] = rom_mem[(mptr + col) % ROM_DEPTH];
      mbase = (mbase + 1) % KERNEL_SIZE;
      mptr  = (mptr + IMAGE_SIZE) % ROM_DEPTH;
    end
    positioned = chain;
  endtask

  initial begin
    int c, ik, rk;
    rst_n = 1'b0;
    cmd   = 2'd0;
    positioned = 1'b0;
    for (int a = 0; a < ROM_DEPTH; a++) rom_mem[a] = WIDTH'(a);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_cmd(2'd1, -1, 2'd0, -1, 1'b0);
    run_cmd(2'd2, -1, 2'd0, -1, 1'b0);
    run_cmd(2'd3, -1, 2'd0, -1, 1'b0);
    run_cmd(2'd2, -1, 2'd0, -1, 1'b0);
    run_cmd(2'd1, 10, 2'd2, -1, 1'b0);
    run_cmd(2'd1, -1, 2'd0, -1, 1'b0);
    repeat (6) run_cmd(2'd3, -1, 2'd0, -1, 1'b0);
    run_cmd(2'd2, -1, 2'd0, -1, 1'b0);
    run_cmd(2'd1, -1, 2'd0, 12, 1'b0);
    run_cmd(2'd2, -1, 2'd0, -1, 1'b0);
    run_cmd(2'd1, -1, 2'd0, -1, 1'b1);
    run_cmd(2'd3, -1, 2'd0, -1, 1'b1);
    run_cmd(2'd2, -1, 2'd0, -1, 1'b1);
    run_cmd(2'd2, -1, 2'd0, -1, 1'b0);

    for (int a = 0; a < ROM_DEPTH; a++) rom_mem[a] = $urandom;
    for (int n = 0; n < 90; n++) begin
      c  = $urandom_range(1, 3);
      ik = ($urandom_range(0, 2) == 0) ? $urandom_range(1, ack_cycle(2'(c)) - 1) : -1;
      rk = ($urandom_range(0, 14) == 0) ? $urandom_range(1, ack_cycle(2'(c)) - 1) : -1;
      if (!positioned) repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(2'(c), ik, 2'($urandom_range(1, 3)), rk, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
